mem_bus_arbiter: RTL and testbench

//  Shares the single p18240 memory port between two requesters: the CPU
//  (controlpath/datapath MAR/MDR traffic) and the debug/loader port.

---
 rtl/mem_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory port between the CPU and the
// debug/loader port. It grants one requester, runs a fixed-latency strobed
// access, then pulses that requester's done for one cycle. Simultaneous
// requests are granted round-robin.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re_L,
  output logic              mem_we_L,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  state_t           state;
  state_t           next_state;
  owner_t           owner;
  owner_t           last_owner;
  owner_t           grant_owner;
  logic             grant_valid;
  logic             we_q;
  logic [CNT_W-1:0] cnt;

  // Choose which requester would be granted this cycle (only acted on in IDLE)
  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_owner = OWN_CPU;
    if (cpu_req && dbg_req) begin
      grant_owner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> ACCESS -> DONE -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (grant_valid) next_state = S_ACCESS;
      S_ACCESS: if (cnt == '0) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched owner/direction
  always_comb begin
    mem_re_L = 1'b1;
    mem_we_L = 1'b1;
    cpu_done = 1'b0;
    dbg_done = 1'b0;
    busy     = (state != S_IDLE);
    if (state == S_ACCESS) begin
      mem_re_L = we_q;
      mem_we_L = ~we_q;
    end
    if (state == S_DONE) begin
      cpu_done = (owner == OWN_CPU);
      dbg_done = (owner == OWN_DBG);
    end
  end

  // Grant latching, latency counter, read-data capture and round-robin history
  always_ff @(posedge clock) begin
    if (reset) begin
      owner      <= OWN_CPU;
      last_owner <= OWN_DBG;
      we_q       <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            owner <= grant_owner;
            cnt   <= CNT_W'(MEM_LAT - 1);
            if (grant_owner == OWN_CPU) begin
              we_q      <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end else begin
              we_q      <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner == OWN_CPU) begin
                cpu_rdata <= mem_rdata;
              end else begin
                dbg_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          last_owner <= owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MEM_LAT = 2).
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done;
  logic        dbg_req, dbg_we;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re_L, mem_we_L, busy;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_re_L(mem_re_L), .mem_we_L(mem_we_L), .busy(busy)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle past the edge before sampling
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (mem_re_L !== 1'b1) begin errors++; $display("FAIL reset_re_L got %b exp 1", mem_re_L); end
    checks++; if (mem_we_L !== 1'b1) begin errors++; $display("FAIL reset_we_L got %b exp 1", mem_we_L); end
    checks++; if ({cpu_done, dbg_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {cpu_done, dbg_done}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); end
    checks++; if ({cpu_rdata, dbg_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {cpu_rdata, dbg_rdata}); end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; mem_rdata = 16'hBEEF;
    tick();  // grant edge -> ACCESS cycle 1
    checks++; if ({mem_re_L, mem_we_L, busy} !== 3'b011) begin errors++; $display("FAIL rd_acc1_strobes got %b exp 011", {mem_re_L, mem_we_L, busy}); end
    checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL rd_mem_addr got %h exp 0040", mem_addr); end
    tick();  // ACCESS cycle 2
    checks++; if ({mem_re_L, cpu_done} !== 2'b00) begin errors++; $display("FAIL rd_acc2 got %b exp 00", {mem_re_L, cpu_done}); end
    tick();  // DONE cycle 3
    checks++; if ({cpu_done, dbg_done, mem_re_L} !== 3'b101) begin errors++; $display("FAIL rd_done got %b exp 101", {cpu_done, dbg_done, mem_re_L}); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_cpu_rdata got %h exp beef", cpu_rdata); end
    cpu_req = 0;
    tick();
    checks++; if ({cpu_done, busy} !== 2'b00) begin errors++; $display("FAIL rd_after got %b exp 00", {cpu_done, busy}); end
  endtask

  task automatic test_alternate();
    reset = 1; tick(); reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_wdata = 16'h1234;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0010; dbg_wdata = 16'h0000;
    mem_rdata = 16'h5678;
    for (int k = 0; k < 4; k++) begin
      tick();  // ACCESS 1
      if (k % 2 == 0) begin
        checks++; if ({mem_re_L, mem_we_L, mem_addr, mem_wdata} !== {2'b10, 16'h2000, 16'h1234}) begin
          errors++; $display("FAIL alt_cpu_acc k=%0d got %b %h %h exp 10 2000 1234", k, {mem_re_L, mem_we_L}, mem_addr, mem_wdata); end
      end else begin
        checks++; if ({mem_re_L, mem_we_L, mem_addr} !== {2'b01, 16'h0010}) begin
          errors++; $display("FAIL alt_dbg_acc k=%0d got %b %h exp 01 0010", k, {mem_re_L, mem_we_L}, mem_addr); end
      end
      tick();  // ACCESS 2
      tick();  // DONE
      checks++; if ({cpu_done, dbg_done} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alt_done k=%0d got %b exp %b", k, {cpu_done, dbg_done}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      if (k % 2 == 1) begin
        checks++; if ({dbg_rdata, cpu_rdata} !== {16'h5678, 16'h0000}) begin
          errors++; $display("FAIL alt_rdata k=%0d got %h %h exp 5678 0000", k, dbg_rdata, cpu_rdata); end
      end
      if (k == 3) begin cpu_req = 0; dbg_req = 0; end
      tick();  // IDLE
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alt_idle k=%0d busy got %b exp 0", k, busy); end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alt_quiet busy got %b exp 0", busy); end
  endtask

  task automatic test_dbg_write_hold();
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0100; dbg_wdata = 16'h00AA;
    mem_rdata = 16'hDEAD;
    tick();  // ACCESS 1
    dbg_we = 0; dbg_addr = 16'hFFFF; dbg_wdata = 16'h5555;
    for (int c = 0; c < 2; c++) begin
      checks++; if ({mem_re_L, mem_we_L, mem_addr, mem_wdata} !== {2'b10, 16'h0100, 16'h00AA}) begin
        errors++; $display("FAIL dbgwr_acc c=%0d got %b %h %h exp 10 0100 00aa", c, {mem_re_L, mem_we_L}, mem_addr, mem_wdata); end
      tick();
    end
    checks++; if ({dbg_done, cpu_done} !== 2'b10) begin errors++; $display("FAIL dbgwr_done got %b exp 10", {dbg_done, cpu_done}); end
    checks++; if (dbg_rdata !== 16'h5678) begin errors++; $display("FAIL dbgwr_rdata got %h exp 5678", dbg_rdata); end
    dbg_req = 0;
    tick();
  endtask

  task automatic test_cpu_drop();
    int pulses;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0080; mem_rdata = 16'hCAFE;
    tick();  // ACCESS 1
    cpu_req = 0;
    tick();  // ACCESS 2
    checks++; if ({busy, mem_re_L} !== 2'b10) begin errors++; $display("FAIL drop_acc got %b exp 10", {busy, mem_re_L}); end
    tick();  // DONE
    checks++; if (cpu_done !== 1'b1) begin errors++; $display("FAIL drop_done got %b exp 1", cpu_done); end
    checks++; if (cpu_rdata !== 16'hCAFE) begin errors++; $display("FAIL drop_rdata got %h exp cafe", cpu_rdata); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL drop_extra_pulses got %0d exp 0", pulses); end
  endtask

  task automatic test_pending_dbg();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300; mem_rdata = 16'h2222;
    tick();  // CPU ACCESS 1
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0400;
    tick(); tick();  // CPU DONE
    checks++; if ({cpu_done, dbg_done} !== 2'b10) begin errors++; $display("FAIL pend_cpu_done got %b exp 10", {cpu_done, dbg_done}); end
    cpu_req = 0;
    tick();  // IDLE, dbg still held
    tick();  // dbg ACCESS 1
    checks++; if ({mem_re_L, mem_addr} !== {1'b0, 16'h0400}) begin errors++; $display("FAIL pend_dbg_acc got %b %h exp 0 0400", mem_re_L, mem_addr); end
    mem_rdata = 16'h3333;
    tick(); tick();  // dbg DONE
    checks++; if ({dbg_done, dbg_rdata, cpu_rdata} !== {1'b1, 16'h3333, 16'h2222}) begin
      errors++; $display("FAIL pend_dbg_done got %b %h %h exp 1 3333 2222", dbg_done, dbg_rdata, cpu_rdata); end
    dbg_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200; mem_rdata = 16'h1111;
    tick();  // ACCESS 1
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", busy); end
    reset = 1; cpu_req = 0;
    tick();
    checks++; if ({busy, mem_re_L, mem_we_L, cpu_done} !== 4'b0110) begin
      errors++; $display("FAIL rstmid_idle got %b exp 0110", {busy, mem_re_L, mem_we_L, cpu_done}); end
    reset = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_done || dbg_done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", pulses); end
    checks++; if ({cpu_rdata, mem_addr} !== 32'h0) begin errors++; $display("FAIL rstmid_regs got %h %h exp 0 0", cpu_rdata, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_alternate();
    test_dbg_write_hold();
    test_cpu_drop();
    test_pending_dbg();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
